fetch_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/ifid_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU.
// Pipeline-register packets and fetch FSM states live here so that decode
// and later stages agree on the same layout.
package cpu_pkg;

  localparam logic [3:0]  OPC_HLT     = 4'hF;
  localparam logic [15:0] INST_BUBBLE = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] inst;
    logic [15:0] pc;
  } ifid_pkt_t;

  localparam ifid_pkt_t IFID_BUBBLE = '{valid: 1'b0, inst: INST_BUBBLE, pc: 16'h0000};

  // True when the instruction word carries the given halt opcode.
  function automatic logic is_halt(input logic [15:0] inst, input logic [3:0] opc);
    return inst[15:12] == opc;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register with hold (stall) and flush (bubble insert).
// Flush beats hold so a redirect always clears the stage even while stalled.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter type  pkt_t  = ifid_pkt_t,
  parameter pkt_t BUBBLE = IFID_BUBBLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  input  logic flush_i,
  input  pkt_t d_i,
  output pkt_t q_o
);

  pkt_t pkt_d;
  pkt_t pkt_q;

  // Choose between bubble, previous contents and new packet.
  always_comb begin
    pkt_d = pkt_q;
    if (flush_i) begin
      pkt_d = BUBBLE;
    end else if (!hold_i) begin
      pkt_d = d_i;
    end
  end

  // Register the stage contents; reset leaves a bubble behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_q <= BUBBLE;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign q_o = pkt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to a variable-latency
// instruction memory, fills IF/ID, and handles stalls, redirects and HLT.
// A memory request is never abandoned: a redirect during an outstanding
// request parks in DRAIN at the old address until the response is swallowed.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = OPC_HLT,
  parameter logic [15:0] BUBBLE_INST = INST_BUBBLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] pc,
  output logic        ifid_valid_o,
  output logic [15:0] ifid_inst_o,
  output logic [15:0] ifid_pc_o,
  output logic [15:0] ifid_pc_plus2_o,
  output logic        hlt_fetched_o
);

  localparam ifid_pkt_t BUBBLE_PKT = '{valid: 1'b0, inst: BUBBLE_INST, pc: 16'h0000};

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  skid_q, skid_d;
  logic [15:0]  drain_addr_q, drain_addr_d;
  logic         req_q, req_d;
  logic         hlt_q, hlt_d;

  logic         ifid_hold;
  logic         ifid_flush;
  ifid_pkt_t    ifid_d;
  ifid_pkt_t    ifid_q;

  logic         accept;
  logic [15:0]  pc_inc;
  logic [15:0]  fetch_addr;

  // While draining, the memory still sees the address of the abandoned fetch.
  assign fetch_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign accept     = req_q & imem_ready_i;
  assign pc_inc     = pc_q + 16'd2;

  // Next-state, next-PC and IF/ID control; redirect outranks everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    drain_addr_d = drain_addr_q;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_d       = '{valid: 1'b1, inst: imem_rdata_i, pc: pc_q};

    if (redirect_i) begin
      ifid_flush = 1'b1;
      pc_d       = {redirect_pc_i[15:1], 1'b0};
      if (req_q && !imem_ready_i) begin
        state_d      = DRAIN;
        drain_addr_d = fetch_addr;
      end else begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) begin
            if (stall_i) begin
              skid_d    = imem_rdata_i;
              ifid_hold = 1'b1;
              state_d   = HOLD;
            end else if (is_halt(imem_rdata_i, HALT_OPCODE)) begin
              state_d = HALTED;
            end else begin
              pc_d = pc_inc;
            end
          end else if (stall_i) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (stall_i) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_d.inst = skid_q;
            if (is_halt(skid_q, HALT_OPCODE)) begin
              state_d = HALTED;
            end else begin
              pc_d    = pc_inc;
              state_d = FETCH;
            end
          end
        end
        DRAIN: begin
          ifid_flush = 1'b1;
          if (accept) begin
            state_d = FETCH;
          end
        end
        HALTED: begin
          if (stall_i) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end

    req_d = (state_d == FETCH) || (state_d == DRAIN);
    hlt_d = (state_d == HALTED);
  end

  // FSM state, PC, skid buffer and registered request/halt outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      skid_q       <= BUBBLE_INST;
      drain_addr_q <= RESET_PC;
      req_q        <= 1'b0;
      hlt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      drain_addr_q <= drain_addr_d;
      req_q        <= req_d;
      hlt_q        <= hlt_d;
    end
  end

  ifid_reg #(
    .pkt_t (ifid_pkt_t),
    .BUBBLE(BUBBLE_PKT)
  ) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (ifid_hold),
    .flush_i(ifid_flush),
    .d_i    (ifid_d),
    .q_o    (ifid_q)
  );

  assign imem_req_o      = req_q;
  assign imem_addr_o     = fetch_addr;
  assign pc              = pc_q;
  assign hlt_fetched_o   = hlt_q;
  assign ifid_valid_o    = ifid_q.valid;
  assign ifid_inst_o     = ifid_q.inst;
  assign ifid_pc_o       = ifid_q.pc;
  assign ifid_pc_plus2_o = ifid_q.pc + 16'd2;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction
// memory, a scoreboard of expected IF/ID instructions, and a queue of
// expected per-cycle status snapshots checked by a separate monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ready_i;
  logic [15:0] imem_rdata_i;
  logic [15:0] pc;
  logic        ifid_valid_o;
  logic [15:0] ifid_inst_o;
  logic [15:0] ifid_pc_o;
  logic [15:0] ifid_pc_plus2_o;
  logic        hlt_fetched_o;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ready_i   (imem_ready_i),
    .imem_rdata_i   (imem_rdata_i),
    .pc             (pc),
    .ifid_valid_o   (ifid_valid_o),
    .ifid_inst_o    (ifid_inst_o),
    .ifid_pc_o      (ifid_pc_o),
    .ifid_pc_plus2_o(ifid_pc_plus2_o),
    .hlt_fetched_o  (hlt_fetched_o)
  );

  typedef struct {
    int          tag;
    logic [15:0] pc;
    logic        req;
    logic [15:0] addr;
    logic        hlt;
    logic        v;
    logic [15:0] inst;
    logic [15:0] ipc;
    logic        chk_ipc;
  } status_t;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } fetch_t;

  status_t     stq[$];
  fetch_t      sbq[$];
  logic [15:0] imem [0:255];
  int          mem_lat = 1;
  int          wcnt = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          tag_ctr = 0;
  bit          mon_en = 1'b0;
  bit          done = 1'b0;
  bit          prev_v = 1'b0;
  logic [15:0] prev_pc = 16'h0;
  logic [15:0] prev_inst = 16'h0;

  // Memory model: answers a held request after mem_lat cycles with a one-cycle ready pulse.
  always @(negedge clk) begin
    if (rst_n !== 1'b1 || imem_req_o !== 1'b1) begin
      imem_ready_i = 1'b0;
      imem_rdata_i = 16'hDEAD;
      wcnt         = 0;
    end else if (wcnt >= mem_lat - 1) begin
      imem_ready_i = 1'b1;
      imem_rdata_i = imem[imem_addr_o[8:1]];
      wcnt         = 0;
    end else begin
      imem_ready_i = 1'b0;
      imem_rdata_i = 16'hDEAD;
      wcnt         = wcnt + 1;
    end
  end

  task automatic cmp(input string nm, input int tag, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s (chk#%0d): got %h, expected %h", nm, tag, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each newly loaded IF/ID instruction and the status queue each cycle.
  always @(negedge clk) begin
    status_t s;
    fetch_t  e;
    cyc++;
    if (cyc > 4000) begin
      $display("[TB] FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
    end
    if (mon_en) begin
      if (ifid_valid_o === 1'b1) begin
        if (!prev_v || ifid_pc_o !== prev_pc || ifid_inst_o !== prev_inst) begin
          if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL unexpected_ifid: got inst %h pc %h, expected nothing", ifid_inst_o, ifid_pc_o);
          end else begin
            e = sbq.pop_front();
            cmp("sb_inst", cyc, ifid_inst_o, e.inst);
            cmp("sb_pc", cyc, ifid_pc_o, e.pc);
            cmp("sb_pc_plus2", cyc, ifid_pc_plus2_o, e.pc + 16'd2);
          end
        end
        prev_v    = 1'b1;
        prev_pc   = ifid_pc_o;
        prev_inst = ifid_inst_o;
      end else begin
        prev_v = 1'b0;
        cmp("bubble_inst", cyc, ifid_inst_o, 16'h0000);
      end
      if (stq.size() > 0) begin
        s = stq.pop_front();
        cmp("pc", s.tag, pc, s.pc);
        cmp("imem_req", s.tag, 16'(imem_req_o), 16'(s.req));
        cmp("imem_addr", s.tag, imem_addr_o, s.addr);
        cmp("hlt_fetched", s.tag, 16'(hlt_fetched_o), 16'(s.hlt));
        cmp("ifid_valid", s.tag, 16'(ifid_valid_o), 16'(s.v));
        cmp("ifid_inst", s.tag, ifid_inst_o, s.inst);
        if (s.chk_ipc) cmp("ifid_pc", s.tag, ifid_pc_o, s.ipc);
      end
    end
    if (done) begin
      cmp("sb_leftover", 0, 16'(sbq.size()), 16'd0);
      cmp("status_leftover", 0, 16'(stq.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [15:0] rpc);
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = rpc;
  endtask

  task automatic checkOutput(input logic [15:0] epc, input logic ereq, input logic [15:0] eaddr,
                             input logic ehlt, input logic ev, input logic [15:0] einst,
                             input logic [15:0] eipc, input logic echk);
    status_t s;
    tag_ctr++;
    s = '{tag: tag_ctr, pc: epc, req: ereq, addr: eaddr, hlt: ehlt, v: ev,
          inst: einst, ipc: eipc, chk_ipc: echk};
    stq.push_back(s);
  endtask

  task automatic expectFetch(input logic [15:0] inst, input logic [15:0] fpc);
    sbq.push_back('{inst: inst, pc: fpc});
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0A00;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    tick();
    mon_en = 1'b1;
    tick();
    checkOutput(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000);

    $display("[TB] zero-wait straight-line fetch up to HLT");
    clearMem();
    mem_lat = 1;
    imem[0] = 16'hB101; imem[1] = 16'hB202; imem[2] = 16'hF000;
    expectFetch(16'hB101, 16'h0000);
    expectFetch(16'hB202, 16'h0002);
    expectFetch(16'hF000, 16'h0004);
    doReset();
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b1, 16'hB101, 16'h0000, 1'b1);
    tick(); checkOutput(16'h0004, 1'b1, 16'h0004, 1'b0, 1'b1, 16'hB202, 16'h0002, 1'b1);
    tick(); checkOutput(16'h0004, 1'b0, 16'h0004, 1'b1, 1'b1, 16'hF000, 16'h0004, 1'b1);
    tick(); checkOutput(16'h0004, 1'b0, 16'h0004, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);

    $display("[TB] redirect out of HALTED");
    imem[16] = 16'h1234; imem[17] = 16'hF000;
    expectFetch(16'h1234, 16'h0020);
    expectFetch(16'hF000, 16'h0022);
    applyStimulus(1'b0, 1'b1, 16'h0020);
    tick(); applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput(16'h0020, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0022, 1'b1, 16'h0022, 1'b0, 1'b1, 16'h1234, 16'h0020, 1'b1);
    tick(); checkOutput(16'h0022, 1'b0, 16'h0022, 1'b1, 1'b1, 16'hF000, 16'h0022, 1'b1);

    $display("[TB] redirect and stall together");
    imem[24] = 16'h2345; imem[25] = 16'hF000;
    expectFetch(16'h2345, 16'h0030);
    expectFetch(16'hF000, 16'h0032);
    applyStimulus(1'b1, 1'b1, 16'h0030);
    tick(); applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput(16'h0030, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput(16'h0030, 1'b0, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0032, 1'b1, 16'h0032, 1'b0, 1'b1, 16'h2345, 16'h0030, 1'b1);
    tick(); checkOutput(16'h0032, 1'b0, 16'h0032, 1'b1, 1'b1, 16'hF000, 16'h0032, 1'b1);
    tick();

    $display("[TB] 3-cycle memory latency");
    clearMem();
    mem_lat = 3;
    imem[0] = 16'h2000; imem[1] = 16'hF000;
    expectFetch(16'h2000, 16'h0000);
    expectFetch(16'hF000, 16'h0002);
    doReset();
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h2000, 16'h0000, 1'b1);
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0002, 1'b0, 16'h0002, 1'b1, 1'b1, 16'hF000, 16'h0002, 1'b1);
    tick();

    $display("[TB] stall with response arriving at pc 0x0006");
    clearMem();
    mem_lat = 1;
    imem[0] = 16'h1000; imem[1] = 16'h1002; imem[2] = 16'h1004;
    imem[3] = 16'h1006; imem[4] = 16'hF000;
    expectFetch(16'h1000, 16'h0000);
    expectFetch(16'h1002, 16'h0002);
    expectFetch(16'h1004, 16'h0004);
    expectFetch(16'h1006, 16'h0006);
    expectFetch(16'hF000, 16'h0008);
    doReset();
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h1000, 16'h0000, 1'b1);
    tick(); checkOutput(16'h0004, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h1002, 16'h0002, 1'b1);
    tick(); checkOutput(16'h0006, 1'b1, 16'h0006, 1'b0, 1'b1, 16'h1004, 16'h0004, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    tick(); checkOutput(16'h0006, 1'b0, 16'h0006, 1'b0, 1'b1, 16'h1004, 16'h0004, 1'b1);
    tick(); checkOutput(16'h0006, 1'b0, 16'h0006, 1'b0, 1'b1, 16'h1004, 16'h0004, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    tick(); checkOutput(16'h0008, 1'b1, 16'h0008, 1'b0, 1'b1, 16'h1006, 16'h0006, 1'b1);
    tick(); checkOutput(16'h0008, 1'b0, 16'h0008, 1'b1, 1'b1, 16'hF000, 16'h0008, 1'b1);
    tick();

    $display("[TB] redirect during outstanding request (drain)");
    clearMem();
    mem_lat = 1;
    imem[0] = 16'h3000; imem[1] = 16'h3002; imem[2] = 16'h3004; imem[3] = 16'h3006;
    imem[4] = 16'h7777; imem[32] = 16'hF000;
    expectFetch(16'h3000, 16'h0000);
    expectFetch(16'h3002, 16'h0002);
    expectFetch(16'h3004, 16'h0004);
    expectFetch(16'h3006, 16'h0006);
    expectFetch(16'hF000, 16'h0040);
    doReset();
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); tick(); tick();
    tick(); checkOutput(16'h0008, 1'b1, 16'h0008, 1'b0, 1'b1, 16'h3006, 16'h0006, 1'b1);
    mem_lat = 3;
    tick(); checkOutput(16'h0008, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0041);
    tick(); applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput(16'h0040, 1'b1, 16'h0008, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0040, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0040, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0040, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0040, 1'b0, 16'h0040, 1'b1, 1'b1, 16'hF000, 16'h0040, 1'b1);
    tick();

    $display("[TB] PC wrap after redirect to 0xFFFE");
    clearMem();
    mem_lat = 1;
    imem[0] = 16'hF000; imem[255] = 16'h4444;
    expectFetch(16'hF000, 16'h0000);
    expectFetch(16'h4444, 16'hFFFE);
    expectFetch(16'hF000, 16'h0000);
    doReset();
    tick();
    tick(); checkOutput(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hF000, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'hFFFE);
    tick(); applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput(16'hFFFE, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h4444, 16'hFFFE, 1'b1);
    tick(); checkOutput(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hF000, 16'h0000, 1'b1);
    tick();

    $display("[TB] reset in the middle of a request");
    clearMem();
    mem_lat = 1;
    imem[0] = 16'h6000; imem[1] = 16'hF000;
    expectFetch(16'h6000, 16'h0000);
    expectFetch(16'h6000, 16'h0000);
    expectFetch(16'hF000, 16'h0002);
    doReset();
    tick();
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h6000, 16'h0000, 1'b1);
    mem_lat = 3;
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b0;
    tick(); checkOutput(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    rst_n = 1'b1;
    tick(); checkOutput(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(); tick();
    tick(); checkOutput(16'h0002, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h6000, 16'h0000, 1'b1);
    tick(); tick();
    tick(); checkOutput(16'h0002, 1'b0, 16'h0002, 1'b1, 1'b1, 16'hF000, 16'h0002, 1'b1);
    tick();

    done = 1'b1;
  end

endmodule
